// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - 3x3 raster window generator and frame sequencer for a Sobel operator (optional macro SOBEL_FRAME_CNT_EN adds frame_cnt)
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  p00,
    output logic [7:0]  p01,
    output logic [7:0]  p02,
    output logic [7:0]  p10,
    output logic [7:0]  p11,
    output logic [7:0]  p12,
    output logic [7:0]  p20,
    output logic [7:0]  p21,
    output logic [7:0]  p22,
    output logic        win_valid,
    output logic        grad_valid,
    output logic [11:0] ctr_col,
    output logic [11:0] ctr_row,
    output logic        busy,
`ifdef SOBEL_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [11:0] LAST_COL = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] LAST_ROW = 12'(IMG_HEIGHT - 1);

    state_t        state_q, state_d;
    logic          drain_q;
    logic [11:0]   col_q, row_q;
    logic          accept, last_pix;
    logic [AW-1:0] addr;
    logic [7:0]    lb1_mem [IMG_WIDTH];
    logic [7:0]    lb2_mem [IMG_WIDTH];
    logic [7:0]    lb1_rd, lb2_rd;
    logic [7:0]    win_q [3][3];
    logic          win_valid_q, grad_valid_q;
    logic [11:0]   ctr1_col_q, ctr1_row_q, ctr_col_q, ctr_row_q;

    assign accept   = pix_valid && pix_ready;
    assign last_pix = accept && (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign addr     = col_q[AW-1:0];
    assign lb1_rd   = lb1_mem[addr];
    assign lb2_rd   = lb2_mem[addr];

    // State register; the second DRAIN cycle is tracked by drain_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
        end
    end

    // Next-state and status outputs; start is only honoured in IDLE
    always_comb begin
        state_d    = state_q;
        pix_ready  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = ACTIVE;
            end
            ACTIVE: begin
                pix_ready = 1'b1;
                if (last_pix) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_q) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Raster position of the next pixel; cleared when a frame begins
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start)) begin
            col_q <= 12'd0;
            row_q <= 12'd0;
        end else if (accept) begin
            if (col_q == LAST_COL) begin
                col_q <= 12'd0;
                row_q <= row_q + 12'd1;
            end else begin
                col_q <= col_q + 12'd1;
            end
        end
    end

    // Line buffers cascade row r-1 into row r-2; contents are never reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[addr] <= pix_in;
            lb2_mem[addr] <= lb1_rd;
        end
    end

    // Window shift register: new column enters at column 2, holds without a pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= 8'd0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb2_rd;
            win_q[1][2] <= lb1_rd;
            win_q[2][2] <= pix_in;
        end
    end

    // Two-stage valid/centre pipeline: stage 1 tracks the window, stage 2 the operator output
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q  <= 1'b0;
            grad_valid_q <= 1'b0;
            ctr1_col_q   <= 12'd0;
            ctr1_row_q   <= 12'd0;
            ctr_col_q    <= 12'd0;
            ctr_row_q    <= 12'd0;
        end else begin
            win_valid_q  <= accept && (row_q >= 12'd2) && (col_q >= 12'd2);
            grad_valid_q <= win_valid_q;
            if (accept) begin
                ctr1_col_q <= col_q - 12'd1;
                ctr1_row_q <= row_q - 12'd1;
            end
            ctr_col_q <= ctr1_col_q;
            ctr_row_q <= ctr1_row_q;
        end
    end

`ifdef SOBEL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) frame_cnt_q <= 16'd0;
        else if (state_q == DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign p00        = win_q[0][0];
    assign p01        = win_q[0][1];
    assign p02        = win_q[0][2];
    assign p10        = win_q[1][0];
    assign p11        = win_q[1][1];
    assign p12        = win_q[1][2];
    assign p20        = win_q[2][0];
    assign p21        = win_q[2][1];
    assign p22        = win_q[2][2];
    assign win_valid  = win_valid_q;
    assign grad_valid = grad_valid_q;
    assign ctr_col    = ctr_col_q;
    assign ctr_row    = ctr_row_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb/tb_sobel_window_ctrl.sv - self-checking bench for sobel_window_ctrl against a frame-level window model
module tb_sobel_window_ctrl;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst, start, pix_valid;
    logic [7:0]  pix_in;
    logic        pix_ready, win_valid, grad_valid, busy, frame_done;
    logic [7:0]  p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic [11:0] ctr_col, ctr_row;
`ifdef SOBEL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22),
        .win_valid(win_valid), .grad_valid(grad_valid),
        .ctr_col(ctr_col), .ctr_row(ctr_row), .busy(busy),
`ifdef SOBEL_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0]  img [NPIX];
    logic [71:0] win_seen [$];
    logic [23:0] ctr_seen [$];
    int fd_count = 0, fd_cyc = -1, first_win_cyc = -1, first_grad_cyc = -1, last_grad_cyc = -1;
    int hold_viol = 0;
    int not_ready = 0;
    logic [71:0] prev_win = '0;
    bit prev_chg = 1'b1;

    wire [71:0] cur_win = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    always @(posedge clk) cyc++;

    // Observer: collects windows/centres, frame_done and hold violations at the negedge
    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid) begin
                if (first_win_cyc < 0) first_win_cyc = cyc;
                win_seen.push_back(cur_win);
            end
            if (grad_valid) begin
                if (first_grad_cyc < 0) first_grad_cyc = cyc;
                last_grad_cyc = cyc;
                ctr_seen.push_back({ctr_row, ctr_col});
            end
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
            if (cur_win !== prev_win && !prev_chg) hold_viol++;
        end
        prev_win = cur_win;
        prev_chg = rst || (pix_valid && pix_ready);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        win_seen.delete();
        ctr_seen.delete();
        first_win_cyc  = -1;
        first_grad_cyc = -1;
        last_grad_cyc  = -1;
        hold_viol      = 0;
        not_ready      = 0;
    endtask

    task automatic fill_img(input bit use_index);
        for (int i = 0; i < NPIX; i++) img[i] = use_index ? 8'(i) : 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams img[first .. first+n-1]; optional random gaps and a stray start mid-frame
    task automatic send_pixels(input int first, input int n, input int gap_pct,
                               input bit start_mid, output int t_last);
        t_last = -1;
        for (int i = first; i < first + n; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                pix_valid = 1'b0;
                pix_in    = 8'($urandom);
                tick();
            end
            pix_valid = 1'b1;
            pix_in    = img[i];
            if (start_mid && i == first + n / 2) start = 1'b1;
            @(negedge clk);
            if (!pix_ready) not_ready++;
            t_last = cyc;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        pix_valid = 1'b0;
        pix_in    = 8'($urandom);
    endtask

    task automatic wait_done(input int base, input string name);
        for (int k = 0; k < 40 && fd_count == base; k++) tick();
        checks++;
        if (fd_count != base + 1) begin
            errors++;
            $display("FAIL %s frame_done count: got %0d expected %0d", name, fd_count, base + 1);
        end
    endtask

    // Compares the collected stream with the windows the frame image implies
    task automatic check_frame(input string name);
        int bad_w, bad_c;
        logic [71:0] ew;
        logic [23:0] ec;
        int k;
        checks++;
        if (win_seen.size() != NWIN) begin
            errors++;
            $display("FAIL %s window count: got %0d expected %0d", name, win_seen.size(), NWIN);
        end
        checks++;
        if (ctr_seen.size() != NWIN) begin
            errors++;
            $display("FAIL %s grad count: got %0d expected %0d", name, ctr_seen.size(), NWIN);
        end
        bad_w = 0;
        bad_c = 0;
        k = 0;
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                ew = {img[(r-2)*W+c-2], img[(r-2)*W+c-1], img[(r-2)*W+c],
                      img[(r-1)*W+c-2], img[(r-1)*W+c-1], img[(r-1)*W+c],
                      img[r*W+c-2],     img[r*W+c-1],     img[r*W+c]};
                ec = {12'(r - 1), 12'(c - 1)};
                if (k < win_seen.size() && win_seen[k] !== ew) begin
                    if (bad_w == 0)
                        $display("FAIL %s window %0d: got %h expected %h", name, k, win_seen[k], ew);
                    bad_w++;
                end
                if (k < ctr_seen.size() && ctr_seen[k] !== ec) begin
                    if (bad_c == 0)
                        $display("FAIL %s centre %0d: got %h expected %h", name, k, ctr_seen[k], ec);
                    bad_c++;
                end
                k++;
            end
        end
        checks++;
        if (bad_w != 0) errors++;
        checks++;
        if (bad_c != 0) errors++;
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL %s window hold: got %0d changes without a pixel, expected 0", name, hold_viol);
        end
        checks++;
        if (not_ready != 0) begin
            errors++;
            $display("FAIL %s pix_ready: got %0d stalls, expected 0", name, not_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pix_valid = 1'b1; pix_in = 8'hAA;
        tick();
        tick();
        rst = 1'b0; start = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, pix_ready, win_valid, grad_valid, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset status: got %b expected 00000",
                     {busy, pix_ready, win_valid, grad_valid, frame_done});
        end
        checks++;
        if ({ctr_row, ctr_col} !== 24'd0 || cur_win !== 72'd0) begin
            errors++;
            $display("FAIL reset data: got ctr %h win %h expected zeros", {ctr_row, ctr_col}, cur_win);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset priority busy: got %b expected 0", busy);
        end
`ifdef SOBEL_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset frame_cnt: got %0d expected 0", frame_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_basic();
        int t;
        int base;
        logic rdy [1:4];
        logic bsy [1:4];
        logic [71:0] first_exp;
        first_exp = {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
        fill_img(1'b1);
        clear_obs();
        base = fd_count;
        pulse_start();
        send_pixels(0, NPIX, 0, 1'b0, t);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            rdy[k] = pix_ready;
            bsy[k] = busy;
        end
        tick();
        check_frame("basic");
        checks++;
        if (win_seen.size() == 0 || win_seen[0] !== first_exp) begin
            errors++;
            $display("FAIL basic first window: got %h expected %h",
                     (win_seen.size() > 0) ? win_seen[0] : 72'hx, first_exp);
        end
        checks++;
        if (first_grad_cyc != first_win_cyc + 1 || first_win_cyc < 0) begin
            errors++;
            $display("FAIL basic grad latency: got win %0d grad %0d expected grad=win+1",
                     first_win_cyc, first_grad_cyc);
        end
        checks++;
        if (ctr_seen.size() == 0 || ctr_seen[0] !== {12'd1, 12'd1} ||
            ctr_seen[ctr_seen.size()-1] !== {12'd4, 12'd6}) begin
            errors++;
            $display("FAIL basic centre ends: got first %h last %h expected 001001 / 004006",
                     (ctr_seen.size() > 0) ? ctr_seen[0] : 24'hx,
                     (ctr_seen.size() > 0) ? ctr_seen[ctr_seen.size()-1] : 24'hx);
        end
        checks++;
        if (last_grad_cyc != t + 2) begin
            errors++;
            $display("FAIL basic last grad cycle: got %0d expected %0d", last_grad_cyc, t + 2);
        end
        checks++;
        if (fd_count != base + 1 || fd_cyc != t + 3) begin
            errors++;
            $display("FAIL basic frame_done: got count %0d at %0d expected count %0d at %0d",
                     fd_count - base, fd_cyc, 1, t + 3);
        end
        checks++;
        if (rdy[1] !== 1'b0 || rdy[2] !== 1'b0 || rdy[3] !== 1'b0 ||
            bsy[3] !== 1'b1 || bsy[4] !== 1'b0) begin
            errors++;
            $display("FAIL basic drain status: got ready %b%b%b busy3 %b busy4 %b expected 000 1 0",
                     rdy[1], rdy[2], rdy[3], bsy[3], bsy[4]);
        end
    endtask

    task automatic test_gaps();
        int t;
        int base;
        fill_img(1'b0);
        clear_obs();
        base = fd_count;
        pulse_start();
        send_pixels(0, NPIX, 35, 1'b0, t);
        wait_done(base, "gaps");
        check_frame("gaps");
    endtask

    task automatic test_abort();
        int t;
        int base;
        fill_img(1'b0);
        clear_obs();
        base = fd_count;
        pulse_start();
        send_pixels(0, 20, 0, 1'b0, t);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (fd_count != base || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: got frame_done %0d busy %b expected 0 and 0", fd_count - base, busy);
        end
        fill_img(1'b0);
        clear_obs();
        pulse_start();
        send_pixels(0, NPIX, 10, 1'b0, t);
        wait_done(base, "abort");
        check_frame("abort");
    endtask

    task automatic test_start_ignored();
        int t;
        int base;
        fill_img(1'b0);
        clear_obs();
        base = fd_count;
        pulse_start();
        send_pixels(0, NPIX, 15, 1'b1, t);
        wait_done(base, "start_ign");
        check_frame("start_ign");
    endtask

    task automatic test_back_to_back();
        int t;
        int base;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < 3; f++) begin
            fill_img(1'b0);
            clear_obs();
            base = fd_count;
            pulse_start();
            send_pixels(0, NPIX, 0, 1'b0, t);
            wait_done(base, "b2b");
            check_frame("b2b");
        end
`ifdef SOBEL_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL b2b frame_cnt: got %0d expected 3", frame_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 8'd0;
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 Parameter IMG_WIDTH, default 640: active pixels per row; legal range 3..4095.
REQ-002 Parameter IMG_HEIGHT, default 480: rows per frame; legal range 3..4095.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a frame.
REQ-006 pix_in  input  8  raster-order grayscale pixel.
REQ-007 pix_valid  input  1  pix_in is valid this cycle.
REQ-008 pix_ready  output  1  block accepts a pixel this cycle; a pixel transfers when pix_valid and pix_ready are both 1.
REQ-009 p00..p22  output  8 each  3x3 window to the Sobel operator; row 0 is oldest, column 2 is newest.
REQ-010 win_valid  output  1  p00..p22 hold a complete window this cycle.
REQ-011 grad_valid  output  1  the Sobel operator's grad_mag/grad_dir are valid this cycle.
REQ-012 ctr_col, ctr_row  output  12 each  window-centre coordinates, aligned with grad_valid.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-015 FSM states: IDLE, ACTIVE, DRAIN, DONE.
REQ-016 IDLE->ACTIVE on start; col and row counters SHALL be cleared on that edge.
REQ-017 pix_ready SHALL be 1 only in ACTIVE; the block SHALL apply no backpressure inside ACTIVE.
REQ-018 Each accepted pixel SHALL advance col; at col = IMG_WIDTH-1, col wraps to 0 and row increments.
REQ-019 Two line buffers, each IMG_WIDTH x 8 bits, SHALL hold rows r-1 and r-2; each accepted pixel SHALL be written at address col.
REQ-020 For a pixel accepted at (r,c), the column shifters SHALL load p22=pix_in, p12=buffer(r-1,c), p02=buffer(r-2,c); the older columns shift from column 2 to column 1 and from column 1 to column 0.
REQ-021 win_valid SHALL be 1 on the cycle after acceptance of (r,c) if r>=2 and c>=2; otherwise it is 0.
REQ-022 Window outputs SHALL hold their values when no pixel is accepted; win_valid is then 0.
REQ-023 grad_valid SHALL be win_valid delayed by one cycle, matching the operator's one-register latency.
REQ-024 ctr_col = c-1 and ctr_row = r-1, registered through the same two-stage delay as grad_valid.
REQ-025 Windows SHALL NOT span rows: columns 0 and 1 of each row produce no win_valid.
REQ-026 Acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL move the FSM ACTIVE->DRAIN.
REQ-027 DRAIN SHALL last 2 cycles, DONE 1 cycle; frame_done = 1 in DONE; DONE->IDLE.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 Windows per frame SHALL equal (IMG_WIDTH-2)*(IMG_HEIGHT-2).
REQ-030 Counters SHALL be 12-bit unsigned; no other wrap-around is permitted.

Reset
REQ-031 On rst: state=IDLE, col=row=0, pix_ready=0, win_valid=0, grad_valid=0, frame_done=0, busy=0, ctr_col=ctr_row=0, p00..p22=0.
REQ-032 Line-buffer contents are not reset; no window is emitted from them until two new rows are accepted.
REQ-033 rst mid-frame SHALL abort the frame with no frame_done; the next start begins a clean frame.
REQ-034 rst SHALL have priority over start and pix_valid in the same cycle.

Configuration
REQ-035 Macro SOBEL_FRAME_CNT_EN defined: output frame_cnt (16 bits) is added; it increments on each frame_done, wraps 0xFFFF->0, and is reset to 0.
REQ-036 SOBEL_FRAME_CNT_EN undefined: no frame_cnt port or counter; all other behaviour is identical.

Verification
REQ-037 With IMG_WIDTH=8, IMG_HEIGHT=6: start, then 48 pixels with pix_in=index -> exactly 24 win_valid, and the first window is p00=0, p01=1, p02=2, p10=8, p11=9, p12=10, p20=16, p21=17, p22=18.
REQ-038 Same frame -> first grad_valid one cycle after first win_valid, with ctr_col=1 and ctr_row=1; last grad_valid has ctr_col=6 and ctr_row=4.
REQ-039 Random pix_valid gaps -> same 24 windows in the same order, and the window outputs hold during gaps.
REQ-040 Last pixel accepted at cycle T -> last grad_valid at T+2, frame_done only at T+3, pix_ready=0 from T+1, busy=0 at T+4.
REQ-041 rst after 20 pixels, then start and a full frame -> no frame_done for the aborted frame, and the new frame gives 24 windows with uncorrupted values.
REQ-042 With SOBEL_FRAME_CNT_EN defined: 3 back-to-back frames -> frame_cnt=3; start pulsed during ACTIVE -> no effect.
